// File: rtl/bf_addsub_pkg.sv
// Shared constants and types for the butterfly add/sub stage that follows the
// modular multiplier: lane widths, moduli and the mode encoding.
package bf_addsub_pkg;

  localparam int KQ     = 3329;
  localparam int DQ     = 8380417;
  localparam int KW     = 12;
  localparam int DW     = 23;
  localparam int DATA_W = 24;

  typedef enum logic {
    MODE_K = 1'b0,
    MODE_D = 1'b1
  } mode_e;

  // One slot of the operand alignment chain.
  typedef struct packed {
    logic              valid;
    mode_e             mode;
    logic              inv;
    logic [DATA_W-1:0] u;
  } dly_t;

  function automatic logic [DATA_W-1:0] pack_dil(input logic [DW-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/bf_addsub_if.sv
// Sample-in / result-out bundle of the butterfly add/sub stage.
// master drives samples and observes results; slave is the stage itself.
interface bf_addsub_if;
  import bf_addsub_pkg::*;

  logic              in_valid;
  logic              mode;
  logic              inv;
  logic [DATA_W-1:0] u_in;
  logic [DATA_W-1:0] wv_in;
  logic              out_valid;
  logic [DATA_W-1:0] x_out;
  logic [DATA_W-1:0] y_out;

  modport master (
    output in_valid, mode, inv, u_in, wv_in,
    input  out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, mode, inv, u_in, wv_in,
    output out_valid, x_out, y_out
  );

endinterface

// File: rtl/bf_addsub_lane.sv
// One modular add/sub lane: registered corrected sum/difference, then an
// optional halving mod Q applied combinationally on the registered values.
module mod_addsub_lane #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] u_i,
  input  logic [W-1:0] wv_i,
  input  logic         inv_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  localparam logic [W:0] QV = (W+1)'(Q);

  logic [W-1:0] s_d, s_q;
  logic [W-1:0] d_d, d_q;
  logic         inv_q;
  logic [W:0]   sum_s;
  logic [W:0]   dif_s;

  // Odd values get Q added first so the shift lands on (v+Q)/2; W+1 bits hold v+Q.
  function automatic logic [W-1:0] halve(input logic [W-1:0] v);
    logic [W:0] t;
    t = {1'b0, v} + (v[0] ? QV : {(W+1){1'b0}});
    return W'(t >> 1);
  endfunction

  always_comb begin
    sum_s = {1'b0, u_i} + {1'b0, wv_i};
    dif_s = {1'b0, u_i} - {1'b0, wv_i};
    if (sum_s >= QV) begin
      s_d = W'(sum_s - QV);
    end else begin
      s_d = W'(sum_s);
    end
    if (u_i < wv_i) begin
      d_d = W'(dif_s + QV);
    end else begin
      d_d = W'(dif_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= {W{1'b0}};
      d_q   <= {W{1'b0}};
      inv_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      d_q   <= d_d;
      inv_q <= inv_i;
    end
  end

  always_comb begin
    if (inv_q) begin
      x_o = halve(s_q);
      y_o = halve(d_q);
    end else begin
      x_o = s_q;
      y_o = d_q;
    end
  end

endmodule

// File: rtl/bf_addsub.sv
// Butterfly add/sub stage: aligns u/mode/inv with the multiplier product, then
// produces x=(u+wv)[/2] and y=(u-wv)[/2] mod q two cycles after wv arrives.
module bf_addsub
  import bf_addsub_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input logic        clk,
  input logic        rst,
  bf_addsub_if.slave io
);

  dly_t              dly_d;
  dly_t              dly_q [MUL_LAT];
  dly_t              tail_s;
  logic              v1_q;
  mode_e             mode1_q;
  logic [DATA_W-1:0] x_d, x_q;
  logic [DATA_W-1:0] y_d, y_q;
  logic              ov_d, ov_q;
  logic [KW-1:0]     khx_s, khy_s, klx_s, kly_s;
  logic [DW-1:0]     dx_s, dy_s;

  always_comb begin
    dly_d.valid = io.in_valid;
    dly_d.mode  = mode_e'(io.mode);
    dly_d.inv   = io.inv;
    dly_d.u     = io.u_in;
  end

  for (genvar i = 0; i < MUL_LAT; i++) begin : g_dly
    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q[i] <= '0;
        end else begin
          dly_q[i] <= dly_d;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q[i] <= '0;
        end else begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
  end

  assign tail_s = dly_q[MUL_LAT-1];

  // All three lanes run every cycle; the delayed mode picks which result is kept.
  mod_addsub_lane #(.W(KW), .Q(KQ)) u_lane_khi (
    .clk   (clk),
    .rst   (rst),
    .u_i   (tail_s.u[2*KW-1:KW]),
    .wv_i  (io.wv_in[2*KW-1:KW]),
    .inv_i (tail_s.inv),
    .x_o   (khx_s),
    .y_o   (khy_s)
  );

  mod_addsub_lane #(.W(KW), .Q(KQ)) u_lane_klo (
    .clk   (clk),
    .rst   (rst),
    .u_i   (tail_s.u[KW-1:0]),
    .wv_i  (io.wv_in[KW-1:0]),
    .inv_i (tail_s.inv),
    .x_o   (klx_s),
    .y_o   (kly_s)
  );

  mod_addsub_lane #(.W(DW), .Q(DQ)) u_lane_dil (
    .clk   (clk),
    .rst   (rst),
    .u_i   (tail_s.u[DW-1:0]),
    .wv_i  (io.wv_in[DW-1:0]),
    .inv_i (tail_s.inv),
    .x_o   (dx_s),
    .y_o   (dy_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      mode1_q <= MODE_K;
    end else begin
      v1_q    <= tail_s.valid;
      mode1_q <= tail_s.mode;
    end
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    ov_d = v1_q;
    if (v1_q) begin
      case (mode1_q)
        MODE_D: begin
          x_d = pack_dil(dx_s);
          y_d = pack_dil(dy_s);
        end
        MODE_K: begin
          x_d = {khx_s, klx_s};
          y_d = {khy_s, kly_s};
        end
        default: begin
          x_d = x_q;
          y_d = y_q;
        end
      endcase
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_q <= 1'b0;
      x_q  <= {DATA_W{1'b0}};
      y_q  <= {DATA_W{1'b0}};
    end else begin
      ov_q <= ov_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign io.out_valid = ov_q;
  assign io.x_out     = x_q;
  assign io.y_out     = y_q;

endmodule
